// File: rtl/energy_window_detector.sv
// Energy detector front end: squares I/Q samples, integrates power over
// non-overlapping windows of 2^LOG2_WIN accepted samples, compares to a threshold.
module energy_window_detector #(
    parameter int unsigned                    IQ_WIDTH  = 16,
    parameter int unsigned                    LOG2_WIN  = 10,
    parameter logic [2*IQ_WIDTH+LOG2_WIN:0]   THRESHOLD = (2*IQ_WIDTH+LOG2_WIN+1)'(1000000)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic signed [IQ_WIDTH-1:0]        i_in,
    input  logic signed [IQ_WIDTH-1:0]        q_in,
    input  logic                              restart,
    output logic                              detect,
    output logic                              dec_valid,
    output logic [2*IQ_WIDTH+LOG2_WIN:0]      energy_out,
    output logic [LOG2_WIN-1:0]               win_count
);

    localparam int unsigned SQ_W  = 2 * IQ_WIDTH;
    localparam int unsigned PWR_W = 2 * IQ_WIDTH + 1;
    localparam int unsigned ACC_W = 2 * IQ_WIDTH + 1 + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;

    logic signed [SQ_W-1:0]  w_i_ext;
    logic signed [SQ_W-1:0]  w_q_ext;
    logic signed [SQ_W-1:0]  w_i_sq;
    logic signed [SQ_W-1:0]  w_q_sq;
    logic [PWR_W-1:0]        w_pwr;
    logic [ACC_W-1:0]        w_sum;
    logic                    w_last;

    logic                    r_s1_valid;
    logic [PWR_W-1:0]        r_pwr;
    logic [ACC_W-1:0]        r_acc;
    logic [LOG2_WIN-1:0]     r_win_count;
    logic                    r_detect;
    logic                    r_dec_valid;
    logic [ACC_W-1:0]        r_energy;

    // Squares are non-negative and at most 2^(2*IQ_WIDTH-2), so they fit the signed product width
    assign w_i_ext = SQ_W'(i_in);
    assign w_q_ext = SQ_W'(q_in);
    assign w_i_sq  = w_i_ext * w_i_ext;
    assign w_q_sq  = w_q_ext * w_q_ext;
    assign w_pwr   = PWR_W'($unsigned(w_i_sq)) + PWR_W'($unsigned(w_q_sq));

    // A window's first sample overwrites whatever the previous window left in r_acc
    assign w_sum  = (r_win_count == '0) ? ACC_W'(r_pwr) : r_acc + ACC_W'(r_pwr);
    assign w_last = r_s1_valid && (r_win_count == WIN_LAST);

    // Stage 1: square; a restart drops the sample presented with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_pwr      <= '0;
        end else if (restart) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_pwr <= w_pwr;
            end
        end
    end

    // Stage 2: accumulate and count accepted samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_win_count <= '0;
        end else if (restart) begin
            r_acc       <= '0;
            r_win_count <= '0;
        end else if (r_s1_valid) begin
            r_acc       <= w_sum;
            r_win_count <= r_win_count + LOG2_WIN'(1);
        end
    end

    // Decision: restart suppresses the pulse even if the last sample is already in stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_detect    <= 1'b0;
            r_dec_valid <= 1'b0;
            r_energy    <= '0;
        end else if (restart) begin
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= w_last;
            if (w_last) begin
                r_energy <= w_sum;
                r_detect <= (w_sum >= THRESHOLD);
            end
        end
    end

    assign detect     = r_detect;
    assign dec_valid  = r_dec_valid;
    assign energy_out = r_energy;
    assign win_count  = r_win_count;

endmodule

// File: tb/tb_energy_window_detector.sv
// Directed bench for energy_window_detector with 16-sample windows and three thresholds.
module tb_energy_window_detector;

    localparam int unsigned IQ_W  = 16;
    localparam int unsigned LOG2W = 4;
    localparam int unsigned ACC_W = 2 * IQ_W + 1 + LOG2W;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic signed [IQ_W-1:0]  i_in;
    logic signed [IQ_W-1:0]  q_in;
    logic                    restart;

    logic                    detect,     detect_hi,     detect_lo;
    logic                    dec_valid,  dec_valid_hi,  dec_valid_lo;
    logic [ACC_W-1:0]        energy_out, energy_out_hi, energy_out_lo;
    logic [LOG2W-1:0]        win_count,  win_count_hi,  win_count_lo;

    int n_checks;
    int n_pass;

    energy_window_detector #(.IQ_WIDTH(IQ_W), .LOG2_WIN(LOG2W), .THRESHOLD(37'd16000000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in), .restart(restart),
        .detect(detect), .dec_valid(dec_valid), .energy_out(energy_out), .win_count(win_count)
    );

    energy_window_detector #(.IQ_WIDTH(IQ_W), .LOG2_WIN(LOG2W), .THRESHOLD(37'd16000001)) dut_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in), .restart(restart),
        .detect(detect_hi), .dec_valid(dec_valid_hi), .energy_out(energy_out_hi), .win_count(win_count_hi)
    );

    energy_window_detector #(.IQ_WIDTH(IQ_W), .LOG2_WIN(LOG2W), .THRESHOLD(37'd1)) dut_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in), .restart(restart),
        .detect(detect_lo), .dec_valid(dec_valid_lo), .energy_out(energy_out_lo), .win_count(win_count_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int i, input int q, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            i_in     = 16'(i);
            q_in     = 16'(q);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (detect !== 1'b0) $display("FAIL reset_detect: got %b expected 0", detect); else n_pass++;
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd0) $display("FAIL reset_energy: got %0d expected 0", energy_out); else n_pass++;
        n_checks++; if (win_count !== 4'd0) $display("FAIL reset_win_count: got %0d expected 0", win_count); else n_pass++;
    endtask

    task automatic test_zero_window;
        feed(0, 0, 15);
        n_checks++; if (win_count !== 4'd14) $display("FAIL zero_count14: got %0d expected 14", win_count); else n_pass++;
        feed(0, 0, 1);
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL zero_early_pulse: got %b expected 0", dec_valid); else n_pass++;
        n_checks++; if (win_count !== 4'd15) $display("FAIL zero_count15: got %0d expected 15", win_count); else n_pass++;
        step();
        n_checks++; if (dec_valid !== 1'b1) $display("FAIL zero_pulse: got %b expected 1", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd0) $display("FAIL zero_energy: got %0d expected 0", energy_out); else n_pass++;
        n_checks++; if (detect_lo !== 1'b0) $display("FAIL zero_detect_thr1: got %b expected 0", detect_lo); else n_pass++;
        n_checks++; if (win_count !== 4'd0) $display("FAIL zero_wrap: got %0d expected 0", win_count); else n_pass++;
        step();
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL zero_pulse_width: got %b expected 0", dec_valid); else n_pass++;
    endtask

    task automatic test_threshold;
        feed(1000, 0, 16);
        step();
        n_checks++; if (dec_valid !== 1'b1) $display("FAIL thr_pulse: got %b expected 1", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd16000000) $display("FAIL thr_energy: got %0d expected 16000000", energy_out); else n_pass++;
        n_checks++; if (detect !== 1'b1) $display("FAIL thr_equal_detect: got %b expected 1", detect); else n_pass++;
        n_checks++; if (detect_hi !== 1'b0) $display("FAIL thr_above_detect: got %b expected 0", detect_hi); else n_pass++;
        n_checks++; if (detect_lo !== 1'b1) $display("FAIL thr_low_detect: got %b expected 1", detect_lo); else n_pass++;
        step();
        step();
        n_checks++; if (detect !== 1'b1) $display("FAIL thr_hold_detect: got %b expected 1", detect); else n_pass++;
        n_checks++; if (energy_out !== 37'd16000000) $display("FAIL thr_hold_energy: got %0d expected 16000000", energy_out); else n_pass++;
    endtask

    task automatic test_extreme;
        feed(-32768, -32768, 16);
        step();
        n_checks++; if (dec_valid !== 1'b1) $display("FAIL ext_pulse: got %b expected 1", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd34359738368) $display("FAIL ext_energy: got %0d expected 34359738368", energy_out); else n_pass++;
        n_checks++; if (detect_hi !== 1'b1) $display("FAIL ext_detect: got %b expected 1", detect_hi); else n_pass++;
    endtask

    task automatic test_restart;
        feed(100, 0, 10);
        n_checks++; if (win_count !== 4'd9) $display("FAIL rs_count9: got %0d expected 9", win_count); else n_pass++;
        in_valid = 1'b1;
        i_in     = 16'sd50;
        q_in     = 16'sd0;
        restart  = 1'b1;
        step();
        restart  = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (win_count !== 4'd0) $display("FAIL rs_count_clear: got %0d expected 0", win_count); else n_pass++;
        n_checks++; if (detect !== 1'b1) $display("FAIL rs_detect_kept: got %b expected 1", detect); else n_pass++;
        n_checks++; if (energy_out !== 37'd34359738368) $display("FAIL rs_energy_kept: got %0d expected 34359738368", energy_out); else n_pass++;
        feed(1, 0, 16);
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL rs_early_pulse: got %b expected 0", dec_valid); else n_pass++;
        step();
        n_checks++; if (dec_valid !== 1'b1) $display("FAIL rs_pulse: got %b expected 1", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd16) $display("FAIL rs_energy: got %0d expected 16", energy_out); else n_pass++;
        n_checks++; if (detect !== 1'b0) $display("FAIL rs_detect: got %b expected 0", detect); else n_pass++;
        // Abort with the window's last sample sitting in stage 1
        feed(1000, 0, 16);
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL rs_late_pulse: got %b expected 0", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd16) $display("FAIL rs_late_energy: got %0d expected 16", energy_out); else n_pass++;
        n_checks++; if (detect !== 1'b0) $display("FAIL rs_late_detect: got %b expected 0", detect); else n_pass++;
        n_checks++; if (win_count !== 4'd0) $display("FAIL rs_late_count: got %0d expected 0", win_count); else n_pass++;
        step();
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL rs_late_pulse2: got %b expected 0", dec_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int pulses;
        int first_at;
        int second_at;
        pulses    = 0;
        first_at  = -1;
        second_at = -1;
        for (int s = 0; s < 64; s++) begin
            in_valid = (s % 2 == 0);
            i_in     = 16'sd3;
            q_in     = 16'sd4;
            step();
            if (dec_valid) begin
                pulses++;
                if (pulses == 1) first_at = s;
                if (pulses == 2) second_at = s;
                n_checks++; if (energy_out !== 37'd400) $display("FAIL gap_energy: got %0d expected 400", energy_out); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (pulses != 2) $display("FAIL gap_pulses: got %0d expected 2", pulses); else n_pass++;
        n_checks++; if (first_at != 31 || second_at != 63)
            $display("FAIL gap_pulse_pos: got %0d,%0d expected 31,63", first_at, second_at); else n_pass++;
        n_checks++; if (win_count !== 4'd0) $display("FAIL gap_wrap: got %0d expected 0", win_count); else n_pass++;
        pulses    = 0;
        first_at  = -1;
        second_at = -1;
        for (int s = 0; s < 33; s++) begin
            in_valid = (s < 32);
            i_in     = 16'sd3;
            q_in     = 16'sd4;
            step();
            if (dec_valid) begin
                pulses++;
                if (pulses == 1) first_at = s;
                if (pulses == 2) second_at = s;
                n_checks++; if (energy_out !== 37'd400) $display("FAIL b2b_energy: got %0d expected 400", energy_out); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (pulses != 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses); else n_pass++;
        n_checks++; if (first_at != 16 || second_at != 32)
            $display("FAIL b2b_pulse_pos: got %0d,%0d expected 16,32", first_at, second_at); else n_pass++;
        n_checks++; if (win_count !== 4'd0) $display("FAIL b2b_wrap: got %0d expected 0", win_count); else n_pass++;
    endtask

    task automatic test_reset_mid;
        feed(1000, 0, 16);
        step();
        n_checks++; if (detect !== 1'b1) $display("FAIL rm_pre_detect: got %b expected 1", detect); else n_pass++;
        feed(5, 0, 8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (detect !== 1'b0) $display("FAIL rm_detect: got %b expected 0", detect); else n_pass++;
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL rm_dec_valid: got %b expected 0", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd0) $display("FAIL rm_energy: got %0d expected 0", energy_out); else n_pass++;
        n_checks++; if (win_count !== 4'd0) $display("FAIL rm_win_count: got %0d expected 0", win_count); else n_pass++;
        feed(2, 0, 16);
        step();
        n_checks++; if (dec_valid !== 1'b1) $display("FAIL rm_pulse: got %b expected 1", dec_valid); else n_pass++;
        n_checks++; if (energy_out !== 37'd64) $display("FAIL rm_energy_after: got %0d expected 64", energy_out); else n_pass++;
        n_checks++; if (detect_lo !== 1'b1) $display("FAIL rm_detect_thr1: got %b expected 1", detect_lo); else n_pass++;
        step();
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL rm_pulse_width: got %b expected 0", dec_valid); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        i_in     = '0;
        q_in     = '0;
        restart  = 1'b0;
        test_reset();
        test_zero_window();
        test_threshold();
        test_extreme();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
